// File: rtl/uart_loopback_core.sv
// uart_loopback_core: autonomous 8N1 UART transmitter (incrementing byte
// pattern) plus an independent receiver, intended for link bring-up with
// Tx wired back to Rx.
// Optional build macro PARITY_EN: adds an even-parity bit between data
// bit 7 and the stop bit on both halves; a parity mismatch blocks the
// rx_data update.
module uart_loopback_core #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic       clk,
  input  logic       rxrst,
  input  logic       txrst,
  input  logic       Rx,
  output logic       Tx,
  output logic [7:0] tx_data,
  output logic [7:0] rx_data
);

  localparam int unsigned GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W    = $clog2(GAP_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CLKS - 1);
  localparam logic [2:0]       LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
`ifdef PARITY_EN
  logic             rx_par_err;
`endif

  // Transmitter FSM: frame sequencing, serial output and pattern counter
  always_ff @(posedge clk) begin
    if (txrst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      Tx       <= 1'b1;
      tx_data  <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_state <= TX_START;
          tx_cnt   <= '0;
          Tx       <= 1'b0;
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
            Tx       <= tx_data[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
`ifdef PARITY_EN
              tx_state <= TX_PARITY;
              Tx       <= ^tx_data;
`else
              tx_state <= TX_STOP;
              Tx       <= 1'b1;
`endif
            end else begin
              tx_idx <= tx_idx + 3'd1;
              Tx     <= tx_data[tx_idx + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_STOP;
            Tx       <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_GAP;
            tx_data  <= tx_data + 8'd1;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_GAP: begin
          if (tx_cnt == GAP_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_START;
            Tx       <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_cnt   <= '0;
          Tx       <= 1'b1;
        end
      endcase
    end
  end

  // Receiver: Rx synchronizer, mid-bit sampling FSM and byte capture
  always_ff @(posedge clk) begin
    if (rxrst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= 8'h00;
      rx_data    <= 8'h00;
`ifdef PARITY_EN
      rx_par_err <= 1'b0;
`endif
    end else begin
      rx_s1   <= Rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          // a start needs the line seen high first, so a low stop bit
          // cannot retrigger a frame on its own
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == LAST_BIT) begin
`ifdef PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt     <= '0;
            rx_par_err <= (^rx_shift) ^ rx_s2;
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
`ifdef PARITY_EN
            if (rx_s2 && !rx_par_err) begin
              rx_data <= rx_shift;
            end
`else
            if (rx_s2) begin
              rx_data <= rx_shift;
            end
`endif
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loopback_core.sv
// Self-checking bench for uart_loopback_core: loopback pattern, resets of
// each half, glitch/framing rejection and random directly-driven frames.
module tb_uart_loopback_core;

  localparam int unsigned CPB = 16;
  localparam int unsigned GAP = 2;
`ifdef PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // rx_data update point after the Tx falling edge (cycles)
  localparam int unsigned RX_UPD = (NBITS - 1) * CPB + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rxrst;
  logic       txrst;
  logic       loop_en;
  logic       rx_drv;
  logic       rx_line;
  logic       tx;
  logic [7:0] tx_data;
  logic [7:0] rx_data;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_loopback_core #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk    (clk),
    .rxrst  (rxrst),
    .txrst  (txrst),
    .Rx     (rx_line),
    .Tx     (tx),
    .tx_data(tx_data),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit dead     = 1'b0;

  logic [7:0]  exp_tx  = 8'h00;
  logic [7:0]  rx_last = 8'h00;
  int unsigned last_n0 = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  a;
    logic [7:0]  b;
    string       name;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  task automatic expect_at(input int unsigned at, input logic [7:0] a,
                           input logic [7:0] b, input string name);
    sb_t e;
    e.at = at; e.a = a; e.b = b; e.name = name;
    sb.push_back(e);
  endtask

  // rx_data monitor: compares against scheduled expectations
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != cyc || (rx_data !== mon_e.a && rx_data !== mon_e.b)) begin
        failures++;
        $display("FAIL %s: rx_data=%h required=%h or %h at cycle %0d (due %0d)",
                 mon_e.name, rx_data, mon_e.a, mon_e.b, cyc, mon_e.at);
      end
    end
  end

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_low(output int unsigned n0);
    bit found = 1'b0;
    n0 = 0;
    for (int i = 0; i < 20 * int'(CPB) && !found; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        n0 = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      checks++;
      failures++;
      dead = 1'b1;
      $display("FAIL tx_start_timeout: got=no start bit required=start bit at cycle %0d", cyc);
    end
  endtask

  // One looped frame: check every Tx bit against the model byte and
  // schedule rx_data expectations just before and after the update point.
  task automatic run_frame(input logic [7:0] pre_a, input logic [7:0] pre_b,
                           input logic [7:0] post_a, input logic [7:0] post_b);
    int unsigned      n0;
    logic [NBITS-1:0] fr;
    if (!dead) begin
      wait_low(n0);
      if (!dead) begin
`ifdef PARITY_EN
        fr = {1'b1, ^exp_tx, exp_tx, 1'b0};
`else
        fr = {1'b1, exp_tx, 1'b0};
`endif
        chk8("tx_data_frame_start", tx_data, exp_tx);
        expect_at(n0 + RX_UPD - 4, pre_a, pre_b, "rx_before_update");
        expect_at(n0 + RX_UPD + 3, post_a, post_b, "rx_after_update");
        for (int i = 0; i < int'(NBITS); i++) begin
          wait_until(n0 + int'(i) * CPB + CPB / 2);
          chk8("tx_frame_bit", 8'(tx), 8'(fr[i]));
        end
        chk8("tx_data_frame_stable", tx_data, exp_tx);
        exp_tx  = exp_tx + 8'd1;
        last_n0 = n0;
      end
    end
  endtask

  task automatic normal_frame();
    logic [7:0] b;
    b = exp_tx;
    run_frame(rx_last, rx_last, b, b);
    rx_last = b;
  endtask

  task automatic wait_gap();
    wait_until(last_n0 + NBITS * CPB + CPB / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_good, input bit stop);
    logic [NBITS-1:0] fr;
`ifdef PARITY_EN
    fr = {stop, (^b) ^ ~par_good, b, 1'b0};
`else
    fr = {stop, b, 1'b0};
    if (par_good) fr[0] = 1'b0;
`endif
    for (int i = 0; i < int'(NBITS); i++) begin
      rx_drv = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int unsigned n0;
    int          k;
    logic [7:0]  old;
    logic [7:0]  b;
    bit          stop;
    bit          pg;

    txrst = 1'b1; rxrst = 1'b1; loop_en = 1'b1; rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    chk8("reset_tx_line", 8'(tx), 8'h01);
    chk8("reset_tx_data", tx_data, 8'h00);
    chk8("reset_rx_data", rx_data, 8'h00);

    // release both halves; Tx must fall one cycle later
    txrst = 1'b0; rxrst = 1'b0;
    @(negedge clk);
    chk8("tx_fall_after_release", 8'(tx), 8'h00);

    // 260 looped frames: rx_data trails tx_data by one frame
    for (int f = 0; f < 260 && !dead; f++) normal_frame();

    // transmitter reset mid-DATA for one cycle
    if (!dead) begin
      old = rx_last;
      k   = int'($urandom_range(0, 7));
      wait_low(n0);
      wait_until(n0 + CPB + int'(k) * CPB + CPB / 2);
      txrst = 1'b1;
      @(negedge clk);
      chk8("tx_abort_line_high", 8'(tx), 8'h01);
      chk8("tx_abort_data_zero", tx_data, 8'h00);
      txrst  = 1'b0;
      exp_tx = 8'h00;
      // frame 00 overlaps the receiver's aborted frame and may be lost
      run_frame(old, 8'h00, old, 8'h00);
      run_frame(old, 8'h00, 8'h01, 8'h01);
      rx_last = 8'h01;
      normal_frame();
      normal_frame();
    end

    // receiver held in reset across three frames, released in a gap
    if (!dead) begin
      wait_gap();
      rxrst = 1'b1;
      @(negedge clk);
      chk8("rx_data_in_reset", rx_data, 8'h00);
      for (int f = 0; f < 3; f++) run_frame(8'h00, 8'h00, 8'h00, 8'h00);
      wait_gap();
      rxrst   = 1'b0;
      rx_last = 8'h00;
      for (int f = 0; f < 3; f++) normal_frame();
    end

    // direct drive on Rx: glitches, framing errors, random frames
    if (!dead) begin
      wait_gap();
      rx_drv  = 1'b1;
      loop_en = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk8("rx_glitch_rejected", rx_data, rx_last);

      send_frame(8'hA5, 1'b1, 1'b0);
      expect_at(cyc + 2, rx_last, rx_last, "rx_framing_error");
      repeat (2 * CPB) @(negedge clk);

      send_frame(8'h5A, 1'b1, 1'b1);
      rx_last = 8'h5A;
      expect_at(cyc + 2, rx_last, rx_last, "rx_direct_frame");
      repeat (2 * CPB) @(negedge clk);

`ifdef PARITY_EN
      send_frame(8'h3C, 1'b0, 1'b1);
      expect_at(cyc + 2, rx_last, rx_last, "rx_parity_error");
      repeat (2 * CPB) @(negedge clk);
`endif

      for (int f = 0; f < 16; f++) begin
        b    = 8'($urandom_range(0, 255));
        stop = ($urandom_range(0, 3) != 0);
        pg   = ($urandom_range(0, 3) != 0);
`ifndef PARITY_EN
        pg = 1'b1;
`endif
        if ($urandom_range(0, 1) == 1) begin
          rx_drv = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge clk);
          rx_drv = 1'b1;
          repeat (CPB) @(negedge clk);
        end
        send_frame(b, pg, stop);
        if (stop && pg) rx_last = b;
        expect_at(cyc + 2, rx_last, rx_last, "rx_random_frame");
        repeat ($urandom_range(2, CPB)) @(negedge clk);
      end
    end

    for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
